// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU arbiter slice: ALU op codes,
//            number of legal ops and the transaction FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int NUM_ALU_OPS = 10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_if
// Purpose  : Bundles the two-port request/response handshake and the shared
//            ALU operand/result bus of alu_arb.
// Ports    : slave  - arbiter side (receives requests, drives ALU/responses)
//            master - client/ALU side (drives requests, ALU result, rsp ready)
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arb_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         i_req_valid;
  logic [1:0]         o_req_ready;
  logic [2*WIDTH-1:0] i_req_a;
  logic [2*WIDTH-1:0] i_req_b;
  logic [7:0]         i_req_op;
  logic [WIDTH-1:0]   o_alu_a;
  logic [WIDTH-1:0]   o_alu_b;
  logic [3:0]         o_alu_op;
  logic [WIDTH-1:0]   i_alu_y;
  logic [1:0]         o_rsp_valid;
  logic [1:0]         i_rsp_ready;
  logic [WIDTH-1:0]   o_rsp_y;
  logic               o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_op, i_alu_y, i_rsp_ready,
    output o_req_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_y,
           o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_op, i_alu_y, i_rsp_ready,
    input  o_req_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_y,
           o_rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way grant logic. Round-robin by default; fixed priority to
//            port 0 when ALU_ARB_FIXED_PRIO_EN is defined (no pointer state).
// Ports    : i_clk, i_rst_n - clock, async active-low reset
//            i_req          - per-port request
//            i_adv          - a grant was accepted this cycle (moves pointer)
//            o_gnt          - one-hot grant (combinational), 0 if no request
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = &{1'b0, i_clk, i_rst_n, i_adv};
  assign o_gnt    = i_req[0] ? 2'b01 : {i_req[1], 1'b0};
`else
  // Port id of the last accepted grant; resets to 1 so port 0 wins first.
  logic r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_last <= 1'b1;
    else if (i_adv) r_last <= o_gnt[1];
  end

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_last ? 2'b01 : 2'b10;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb
// Purpose  : Arbitrates two request ports onto one shared combinational ALU.
//            One transaction in flight: IDLE (grant) -> EXEC (capture ALU
//            result) -> RESP (hold response until owning port accepts).
//            Option macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins).
// Ports    : i_clk   - clock
//            i_rst_n - asynchronous active-low reset
//            bus     - alu_arb_if.slave (requests, ALU bus, responses)
// Revision : 1.0 - initial release
// ============================================================================
module alu_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NOPS  = NUM_ALU_OPS
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  alu_arb_if.slave bus
);

  localparam logic [4:0] c_nops = 5'(NOPS);

  state_e           r_state;
  logic             r_port;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_y;
  logic             r_rsp_err;

  logic [1:0] w_gnt;
  logic [1:0] w_ready;
  logic       w_hs;
  logic       w_sel;
  logic       w_illegal;

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (bus.i_req_valid),
    .i_adv   (w_hs),
    .o_gnt   (w_gnt)
  );

  // Ready is a combinational echo of the grant, only while idle and out of
  // reset, so a request present during reset is never acknowledged.
  assign w_ready   = (r_state == ST_IDLE && i_rst_n) ? w_gnt : 2'b00;
  assign w_hs      = |(bus.i_req_valid & w_ready);
  assign w_sel     = w_ready[1];
  assign w_illegal = {1'b0, r_op} >= c_nops;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_port      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_y     <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_port  <= w_sel;
            r_a     <= bus.i_req_a[(w_sel ? WIDTH : 0) +: WIDTH];
            r_b     <= bus.i_req_b[(w_sel ? WIDTH : 0) +: WIDTH];
            r_op    <= bus.i_req_op[(w_sel ? 4 : 0) +: 4];
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_y     <= w_illegal ? '0 : bus.i_alu_y;
          r_rsp_err   <= w_illegal;
          r_rsp_valid <= r_port ? 2'b10 : 2'b01;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owning port's ready can retire the response.
          if (bus.i_rsp_ready[r_port]) begin
            r_rsp_valid <= 2'b00;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_alu_a     = r_a;
  assign bus.o_alu_b     = r_b;
  assign bus.o_alu_op    = r_op;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_y     = r_rsp_y;
  assign bus.o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arb
// Purpose  : Self-checking bench for alu_arb. Provides a behavioural ALU on
//            the shared bus and predicts grants/results from the arbitration
//            and ALU rules. Honours ALU_ARB_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arb;
  localparam int W = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arb_if #(.WIDTH(W)) bus ();

  alu_arb #(.WIDTH(W), .NOPS(10)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int last_gnt = 1;   // model of the last granted port

  function automatic logic [W-1:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b,
                                           logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return W'($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd9:    return (a < b) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // External ALU: returns junk for illegal ops so the arbiter must zero them.
  function automatic logic [W-1:0] alu_hw(logic [W-1:0] a, logic [W-1:0] b,
                                          logic [3:0] op);
    return (op < 4'd10) ? alu_ref(a, b, op) : (a ^ 32'hDEADBEEF);
  endfunction

  assign bus.i_alu_y = alu_hw(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  function automatic int pick(logic [1:0] v);
    if (v == 2'b11) return FIXED ? 0 : 1 - last_gnt;
    return v[1] ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req_valid = 2'b11;
    bus.i_req_a = {32'd7, 32'd9};
    bus.i_req_b = {32'd1, 32'd2};
    bus.i_req_op = 8'h10;
    bus.i_rsp_ready = 2'b00;
    repeat (2) tick();
    n_cmp++; if (bus.o_req_ready !== 2'b00) begin n_mis++;
      $display("FAIL rst_ready: got %b want 00", bus.o_req_ready); end
    n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_mis++;
      $display("FAIL rst_rsp_valid: got %b want 00", bus.o_rsp_valid); end
    n_cmp++; if ({bus.o_rsp_y, bus.o_rsp_err} !== '0) begin n_mis++;
      $display("FAIL rst_rsp: got y=%h err=%b want 0/0", bus.o_rsp_y, bus.o_rsp_err); end
    n_cmp++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op} !== '0) begin n_mis++;
      $display("FAIL rst_alu: got %h %h %h want 0", bus.o_alu_a, bus.o_alu_b, bus.o_alu_op); end
    bus.i_req_valid = 2'b00;
    rst_n = 1'b1;
    last_gnt = 1;
    tick();
  endtask

  task automatic test_single();
    bus.i_req_valid = 2'b01;
    bus.i_req_a = {32'hAAAA_0000, 32'd5};
    bus.i_req_b = {32'h0000_BBBB, 32'd3};
    bus.i_req_op = {4'd1, 4'd0};
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_mis++;
      $display("FAIL single_ready: got %b want 01", bus.o_req_ready); end
    last_gnt = 0;
    tick();
    bus.i_req_valid = 2'b00;
    n_cmp++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op} !== {32'd5, 32'd3, 4'd0}) begin n_mis++;
      $display("FAIL single_exec: got %h %h %h want 5 3 0", bus.o_alu_a, bus.o_alu_b, bus.o_alu_op); end
    n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_mis++;
      $display("FAIL single_early: got %b want 00", bus.o_rsp_valid); end
    tick();
    n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_y, bus.o_rsp_err} !== {2'b01, 32'd8, 1'b0}) begin n_mis++;
      $display("FAIL single_rsp: got v=%b y=%h e=%b want 01 8 0", bus.o_rsp_valid, bus.o_rsp_y, bus.o_rsp_err); end
    bus.i_rsp_ready = 2'b01;
    tick();
    bus.i_rsp_ready = 2'b00;
    n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_mis++;
      $display("FAIL single_retire: got %b want 00", bus.o_rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] a0, a1, b0, b1, ey;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_gnt = 1;
    bus.i_req_valid = 2'b11;
    bus.i_rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      int ep;
      ep = FIXED ? 0 : (i % 2);
      a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
      bus.i_req_a = {a1, a0};
      bus.i_req_b = {b1, b0};
      bus.i_req_op = {4'd1, 4'd1};
      ey = (ep == 1) ? a1 - b1 : a0 - b0;
      #1;
      n_cmp++; if (bus.o_req_ready !== 2'(1 << ep)) begin n_mis++;
        $display("FAIL rr_grant%0d: got %b want %b", i, bus.o_req_ready, 2'(1 << ep)); end
      last_gnt = ep;
      tick();
      tick();
      n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_y} !== {2'(1 << ep), ey}) begin n_mis++;
        $display("FAIL rr_rsp%0d: got %b %h want %b %h", i, bus.o_rsp_valid, bus.o_rsp_y, 2'(1 << ep), ey); end
      tick();
    end
    bus.i_req_valid = 2'b00;
    bus.i_rsp_ready = 2'b00;
  endtask

  task automatic test_illegal();
    bus.i_req_valid = 2'b10;
    bus.i_req_a = {32'h1234_5678, 32'd0};
    bus.i_req_b = {32'h0000_0001, 32'd0};
    bus.i_req_op = {4'd12, 4'd0};
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b10) begin n_mis++;
      $display("FAIL illegal_ready: got %b want 10", bus.o_req_ready); end
    last_gnt = 1;
    tick();
    bus.i_req_valid = 2'b00;
    tick();
    n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_y, bus.o_rsp_err} !== {2'b10, 32'd0, 1'b1}) begin n_mis++;
      $display("FAIL illegal_rsp: got v=%b y=%h e=%b want 10 0 1", bus.o_rsp_valid, bus.o_rsp_y, bus.o_rsp_err); end
    bus.i_rsp_ready = 2'b10;
    tick();
    bus.i_rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ey0, ey1;
    bus.i_req_valid = 2'b01;
    bus.i_req_a = {32'd100, 32'hF0F0_0000};
    bus.i_req_b = {32'd58, 32'h0F0F_FFFF};
    bus.i_req_op = {4'd1, 4'd3};
    ey0 = 32'hFFFF_FFFF;
    ey1 = 32'd42;
    #1;
    last_gnt = 0;
    tick();
    bus.i_req_valid = 2'b10;           // port 1 must wait
    tick();
    bus.i_rsp_ready = 2'b10;           // non-owner ready must be ignored
    for (int h = 0; h < 5; h++) begin
      n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_y, bus.o_req_ready} !== {2'b01, ey0, 2'b00}) begin n_mis++;
        $display("FAIL bp_hold%0d: got v=%b y=%h rdy=%b want 01 %h 00", h, bus.o_rsp_valid, bus.o_rsp_y, bus.o_req_ready, ey0); end
      tick();
    end
    bus.i_rsp_ready = 2'b01;
    tick();
    bus.i_rsp_ready = 2'b00;
    n_cmp++; if (bus.o_req_ready !== 2'b10) begin n_mis++;
      $display("FAIL bp_waiter: got %b want 10", bus.o_req_ready); end
    last_gnt = 1;
    tick();
    bus.i_req_valid = 2'b00;
    tick();
    n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_y} !== {2'b10, ey1}) begin n_mis++;
      $display("FAIL bp_second: got %b %h want 10 %h", bus.o_rsp_valid, bus.o_rsp_y, ey1); end
    bus.i_rsp_ready = 2'b10;
    tick();
    bus.i_rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [1:0] v;
      logic [W-1:0] a0, a1, b0, b1, ea, eb, ey;
      logic [3:0] o0, o1, eo;
      logic ee;
      int p, hold;
      v = 2'($urandom_range(0, 3));
      a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom;
      o0 = 4'($urandom_range(0, 15)); o1 = 4'($urandom_range(0, 15));
      bus.i_req_valid = v;
      bus.i_req_a = {a1, a0};
      bus.i_req_b = {b1, b0};
      bus.i_req_op = {o1, o0};
      #1;
      if (v == 2'b00) begin
        n_cmp++; if ({bus.o_req_ready, bus.o_rsp_valid} !== 4'b0) begin n_mis++;
          $display("FAIL rnd_idle%0d: got rdy=%b v=%b want 00 00", it, bus.o_req_ready, bus.o_rsp_valid); end
        tick();
        continue;
      end
      p = pick(v);
      ea = p ? a1 : a0; eb = p ? b1 : b0; eo = p ? o1 : o0;
      ee = (eo >= 4'd10);
      ey = ee ? '0 : alu_ref(ea, eb, eo);
      n_cmp++; if (bus.o_req_ready !== 2'(1 << p)) begin n_mis++;
        $display("FAIL rnd_grant%0d: got %b want %b", it, bus.o_req_ready, 2'(1 << p)); end
      last_gnt = p;
      tick();
      bus.i_req_valid = 2'($urandom_range(0, 3));
      n_cmp++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_req_ready} !== {ea, eb, eo, 2'b00}) begin n_mis++;
        $display("FAIL rnd_exec%0d: got %h %h %h rdy=%b want %h %h %h 00", it, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_req_ready, ea, eb, eo); end
      tick();
      bus.i_req_valid = 2'b00;
      hold = $urandom_range(0, 3);
      bus.i_rsp_ready = 2'(1 << (1 - p));
      for (int h = 0; h <= hold; h++) begin
        n_cmp++; if ({bus.o_rsp_valid, bus.o_rsp_y, bus.o_rsp_err, bus.o_req_ready} !== {2'(1 << p), ey, ee, 2'b00}) begin n_mis++;
          $display("FAIL rnd_rsp%0d: got v=%b y=%h e=%b rdy=%b want %b %h %b 00", it, bus.o_rsp_valid, bus.o_rsp_y, bus.o_rsp_err, bus.o_req_ready, 2'(1 << p), ey, ee); end
        if (h < hold) tick();
      end
      bus.i_rsp_ready = 2'(1 << p);
      tick();
      bus.i_rsp_ready = 2'b00;
      n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_mis++;
        $display("FAIL rnd_retire%0d: got %b want 00", it, bus.o_rsp_valid); end
    end
  endtask

  task automatic test_reset_mid();
    bus.i_req_valid = 2'b11;
    bus.i_req_a = {32'd77, 32'd66};
    bus.i_req_b = {32'd11, 32'd22};
    bus.i_req_op = {4'd0, 4'd0};
    tick();
    bus.i_req_valid = 2'b00;
    rst_n = 1'b0;                      // asynchronous, mid-EXEC
    #1;
    n_cmp++; if ({bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_err} !== 5'b0) begin n_mis++;
      $display("FAIL midrst_ctl: got rdy=%b v=%b e=%b want 0", bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_err); end
    n_cmp++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_rsp_y} !== '0) begin n_mis++;
      $display("FAIL midrst_data: got %h %h %h %h want 0", bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_rsp_y); end
    tick();
    rst_n = 1'b1;
    last_gnt = 1;
    bus.i_rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.o_rsp_valid !== 2'b00) begin n_mis++;
        $display("FAIL midrst_norsp%0d: got %b want 00", c, bus.o_rsp_valid); end
    end
    bus.i_rsp_ready = 2'b00;
    bus.i_req_valid = 2'b11;
    #1;
    n_cmp++; if (bus.o_req_ready !== 2'b01) begin n_mis++;
      $display("FAIL midrst_grant: got %b want 01", bus.o_req_ready); end
    bus.i_req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_illegal();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 Parameter NOPS, default 10, number of legal ALU op codes (0..NOPS-1).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_req_valid  input  2  per-port request valid (bit p = port p).
REQ-006 o_req_ready  output  2  per-port request accepted this cycle.
REQ-007 i_req_a  input  2*WIDTH  port p operand a in bits [p*WIDTH +: WIDTH].
REQ-008 i_req_b  input  2*WIDTH  port p operand b, same packing.
REQ-009 i_req_op  input  8  port p 4-bit op in bits [p*4 +: 4] (0=ADD..9=SLTU).
REQ-010 o_alu_a, o_alu_b  output  WIDTH each  operands driven to shared ALU.
REQ-011 o_alu_op  output  4  op driven to shared ALU.
REQ-012 i_alu_y  input  WIDTH  combinational ALU result.
REQ-013 o_rsp_valid  output  2  per-port response valid.
REQ-014 i_rsp_ready  input  2  per-port response accepted.
REQ-015 o_rsp_y  output  WIDTH  registered result, valid for the port flagged in o_rsp_valid.
REQ-016 o_rsp_err  output  1  illegal op flag, qualified by o_rsp_valid.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-018 IDLE: o_req_ready is one-hot for the granted port when any i_req_valid set, else 0; handshake = valid & ready.
REQ-019 On handshake: latch port id, a, b, op into issue registers; go to EXEC.
REQ-020 o_alu_a/b/op SHALL be driven only from issue registers, never combinationally from request inputs.
REQ-021 EXEC, one cycle: capture i_alu_y into o_rsp_y; go to RESP.
REQ-022 Op >= NOPS: o_rsp_y = 0 and o_rsp_err = 1; otherwise o_rsp_err = 0.
REQ-023 RESP: o_rsp_valid bit of owning port = 1, other bit 0; o_rsp_y/o_rsp_err stable until i_rsp_ready of that port is 1.
REQ-024 RESP with owning i_rsp_ready = 1: go to IDLE next cycle; i_rsp_ready of the non-owning port is ignored.
REQ-025 Latency: handshake in cycle N -> o_rsp_valid in cycle N+2; best-case throughput one transaction per 3 cycles.
REQ-026 Round-robin: both ports valid in IDLE -> grant port other than last granted; single valid port always granted.
REQ-027 Last-granted pointer updates only on handshake.
REQ-028 o_req_ready = 0 in EXEC and RESP; requests wait, no dropping.
REQ-029 Deassertion of i_req_valid before handshake has no effect on state.

Reset
REQ-030 While i_rst_n = 0: state IDLE, o_req_ready = 0, o_rsp_valid = 0, o_rsp_y = 0, o_rsp_err = 0, o_alu_a/b = 0, o_alu_op = 0.
REQ-031 Last-granted pointer resets to 1, so port 0 wins the first contention.
REQ-032 Reset asserted mid-transaction (EXEC or RESP) discards it; no response issued after release.

Configuration
REQ-033 Macro ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins contention; pointer logic absent.
REQ-034 Macro undefined: round-robin per REQ-026/027.

Structure
REQ-035 Shared package alu_pkg holds ALU op enum (ADD..SLTU, 4 bits), NUM_ALU_OPS = 10, and FSM state enum.
REQ-036 One sub-module rr_arb2: 2-way grant logic with pointer, selected by ALU_ARB_FIXED_PRIO_EN.

Verification
REQ-037 Port 0 only: a=5, b=3, op=0 -> o_alu_op=0 in EXEC; o_rsp_valid=2'b01, o_rsp_y=8 at N+2.
REQ-038 Both valid every cycle after reset, op=1 -> grants 0,1,0,1 (round-robin); with macro -> 0,0,0,0.
REQ-039 Port 1 op=4'd12 -> o_rsp_valid=2'b10, o_rsp_err=1, o_rsp_y=0.
REQ-040 i_rsp_ready held 0 for 5 cycles in RESP -> o_rsp_y stable, o_req_ready=0 throughout, new req waits.
REQ-041 i_rst_n pulsed low in EXEC -> all outputs 0, no response after release, next contention grants port 0.
